conv_layer_controller: RTL and testbench
========================================

Name: conv_layer_controller

Overview:
Sequencer for one convolutional layer instance. It streams kernel weights and biases from a ready/valid source into the layer's kernel RAM write port, then issues the layer's start pulse on request. It watches the layer's output handshakes to detect completion and reports done to the network-level sequencer. It sits between the top-level network controller and a single conv layer; loading and running are mutually exclusive because the layer's RAM address is shared between write and read.

Parameters:
N_CONVOLUTIONS, 1, number of kernels (output channels) in the controlled layer
KERNEL_HEIGHT, 3, kernel height in words
KERNEL_WIDTH, 2, kernel width in words
WORD_SIZE, 16, bits per weight word
OUTPUTS_PER_RUN, 4, output handshakes that complete one layer run (must be >=1)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
load_i  in  1  request to (re)load all kernel memories
run_i  in  1  request to run the layer once
w_valid_i  in  1  weight stream valid
w_yumi_o  out  1  weight stream accept
w_data_i  in  WORD_SIZE  weight stream word
mem_addr_o  out  AW  layer RAM write address, AW = $clog2(N_CONVOLUTIONS+1)+$clog2(KS+1), KS = KERNEL_HEIGHT*KERNEL_WIDTH
mem_data_o  out  WORD_SIZE  layer RAM write data
wen_o  out  1  layer RAM write enable
start_o  out  1  layer start pulse
layer_valid_i  in  1  layer output valid (monitored only)
layer_ready_i  in  1  downstream ready on layer output (monitored only)
busy_o  out  1  high in any state other than eIDLE
loaded_o  out  1  all kernels hold valid weights
done_o  out  1  one-cycle run-complete pulse
err_o  out  1  one-cycle pulse for run_i while not loaded

Behaviour:
- Reset (async, reset_n_i=0): state eIDLE. Counters k_r and c_r, out_cnt_r, and loaded_r = 0. All outputs are 0.
- Address format: mem_addr_o = {c_r+1, k_r}. The upper field holds the kernel index plus 1; 0 means no kernel selected. The lower field k_r runs 0..KS; KS entries are weights and index KS is the bias.
- mem_data_o = w_data_i combinationally.
- States: eIDLE, eLOAD, eSTART, eRUN, eDONE.
- eIDLE:
  - load_i -> eLOAD. Clears loaded_r, k_r and c_r.
  - else run_i with loaded_r=1 -> eSTART.
  - else run_i with loaded_r=0 -> stay in eIDLE and pulse err_o.
  - load_i and run_i together: load wins, no err_o.
- eLOAD:
  - w_yumi_o = w_valid_i and wen_o = w_valid_i, both combinational. A write occurs every cycle valid is high.
  - On each accept, k_r increments. At k_r==KS, k_r wraps to 0 and c_r increments.
  - On the accept with c_r==N_CONVOLUTIONS-1 and k_r==KS: next state eIDLE, loaded_r<=1.
  - Total accepts per load = N_CONVOLUTIONS*(KS+1). Gaps in w_valid_i stall without changing the counters.
- eSTART:
  - start_o=1 for exactly one cycle, out_cnt_r<=0, then eRUN.
- eRUN:
  - An output handshake is a cycle with layer_valid_i && layer_ready_i; each increments out_cnt_r.
  - The handshake with out_cnt_r==OUTPUTS_PER_RUN-1 -> eDONE.
  - Handshakes outside eRUN are ignored.
- eDONE:
  - done_o=1 for one cycle, then eIDLE. loaded_r stays set, so a rerun needs no reload.
- In every state except eLOAD: w_yumi_o=0, wen_o=0, mem_addr_o=0.
- In any state other than eIDLE: load_i and run_i are ignored, with no err_o.
- busy_o is registered state decode: 1 in eLOAD, eSTART, eRUN and eDONE.
- Reset asserted mid-eLOAD leaves loaded_o=0; the partial load is abandoned.
- Reset asserted mid-eRUN returns to eIDLE with no done_o.
- Counter widths: k_r is $clog2(KS+1) bits, c_r is $clog2(N_CONVOLUTIONS+1) bits, out_cnt_r is $clog2(OUTPUTS_PER_RUN+1) bits. No counter may overflow its width.

Test Plan:
- Load, N_CONVOLUTIONS=2, KS=6, continuous w_valid_i with data 1..14:
  - 14 writes, with addresses {1,0}..{1,6} then {2,0}..{2,6} and data 1..14 in order.
  - loaded_o rises the cycle after the 14th accept; busy_o falls at the same time.
- Load with w_valid_i toggling every other cycle:
  - No write on low-valid cycles.
  - Address sequence identical to the previous test.
  - Completes in 28 cycles after entering eLOAD.
- run_i before any load:
  - err_o pulses once, start_o stays 0, state stays eIDLE.
- Loaded, run_i with OUTPUTS_PER_RUN=4, layer handshakes on 4 cycles interleaved with cycles where valid=1 and ready=0:
  - start_o single pulse.
  - done_o exactly one cycle after the 4th handshake.
  - Stalled cycles are not counted.
- load_i and run_i together in eIDLE while loaded:
  - Load wins: loaded_o drops, no start_o, no err_o.
- reset_n_i low for 1 cycle midway through a load (after 5 of 14 accepts):
  - All outputs 0 immediately (async).
  - Next run_i gives err_o.
  - A fresh load restarts at address {1,0}.

Source files
------------

// File: rtl/conv_layer_controller.sv
// conv_layer_controller: loads kernel weights/biases into one conv layer's
// RAM from a ready/valid stream, then starts the layer and counts output
// handshakes to report completion. Load and run never overlap because the
// layer RAM address is shared between its write and read sides.
module conv_layer_controller #(
  parameter int N_CONVOLUTIONS  = 1,
  parameter int KERNEL_HEIGHT   = 3,
  parameter int KERNEL_WIDTH    = 2,
  parameter int WORD_SIZE       = 16,
  parameter int OUTPUTS_PER_RUN = 4,
  localparam int KS = KERNEL_HEIGHT * KERNEL_WIDTH,
  localparam int KW = $clog2(KS + 1),
  localparam int CW = $clog2(N_CONVOLUTIONS + 1),
  localparam int AW = CW + KW
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 load_i,
  input  logic                 run_i,
  input  logic                 w_valid_i,
  output logic                 w_yumi_o,
  input  logic [WORD_SIZE-1:0] w_data_i,
  output logic [AW-1:0]        mem_addr_o,
  output logic [WORD_SIZE-1:0] mem_data_o,
  output logic                 wen_o,
  output logic                 start_o,
  input  logic                 layer_valid_i,
  input  logic                 layer_ready_i,
  output logic                 busy_o,
  output logic                 loaded_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int OW = $clog2(OUTPUTS_PER_RUN + 1);

  typedef enum logic [2:0] {eIDLE, eLOAD, eSTART, eRUN, eDONE} state_e;

  state_e        r_state, w_state_nxt;
  logic [KW-1:0] r_k;
  logic [CW-1:0] r_c;
  logic [OW-1:0] r_out_cnt;
  logic          r_loaded;

  logic w_accept, w_hs, w_k_last, w_c_last, w_out_last;

  assign w_accept   = (r_state == eLOAD) && w_valid_i;
  assign w_hs       = (r_state == eRUN) && layer_valid_i && layer_ready_i;
  assign w_k_last   = (r_k == KW'(KS));
  assign w_c_last   = (r_c == CW'(N_CONVOLUTIONS - 1));
  assign w_out_last = (r_out_cnt == OW'(OUTPUTS_PER_RUN - 1));

  assign mem_data_o = w_data_i;
  assign loaded_o   = r_loaded;
  assign busy_o     = (r_state != eIDLE);

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= eIDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state and per-state output decode
  always_comb begin
    w_state_nxt = r_state;
    w_yumi_o    = 1'b0;
    wen_o       = 1'b0;
    mem_addr_o  = '0;
    start_o     = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (r_state)
      eIDLE: begin
        if (load_i)                   w_state_nxt = eLOAD;
        else if (run_i && r_loaded)   w_state_nxt = eSTART;
        else if (run_i)               err_o       = 1'b1;
      end
      eLOAD: begin
        w_yumi_o   = w_valid_i;
        wen_o      = w_valid_i;
        // Upper field is kernel index + 1 so that 0 means "no kernel".
        mem_addr_o = {r_c + CW'(1), r_k};
        if (w_accept && w_k_last && w_c_last) w_state_nxt = eIDLE;
      end
      eSTART: begin
        start_o     = 1'b1;
        w_state_nxt = eRUN;
      end
      eRUN: begin
        if (w_hs && w_out_last) w_state_nxt = eDONE;
      end
      eDONE: begin
        done_o      = 1'b1;
        w_state_nxt = eIDLE;
      end
      default: w_state_nxt = eIDLE;
    endcase
  end

  // Weight/bias address counters and the loaded flag
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_k      <= '0;
      r_c      <= '0;
      r_loaded <= 1'b0;
    end else if (r_state == eIDLE && load_i) begin
      r_k      <= '0;
      r_c      <= '0;
      r_loaded <= 1'b0;
    end else if (w_accept) begin
      if (w_k_last) begin
        r_k <= '0;
        // On the final bias c reaches N_CONVOLUTIONS, which still fits.
        r_c <= r_c + CW'(1);
        if (w_c_last) r_loaded <= 1'b1;
      end else begin
        r_k <= r_k + KW'(1);
      end
    end
  end

  // Output handshake counter for the current run
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)            r_out_cnt <= '0;
    else if (r_state == eSTART) r_out_cnt <= '0;
    else if (w_hs)             r_out_cnt <= r_out_cnt + OW'(1);
  end

endmodule

// File: tb/tb_conv_layer_controller.sv
// Directed + randomized bench for conv_layer_controller with two kernels of
// 3x2 weights. Expected write addresses come from the flat write index.
module tb_conv_layer_controller;

  localparam int N   = 2;
  localparam int KH  = 3;
  localparam int KWD = 2;
  localparam int WS  = 16;
  localparam int OPR = 4;
  localparam int KS  = KH * KWD;
  localparam int KB  = $clog2(KS + 1);
  localparam int AW  = $clog2(N + 1) + KB;
  localparam int TOTAL = N * (KS + 1);

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          load_i, run_i, w_valid_i, w_yumi_o;
  logic [WS-1:0] w_data_i, mem_data_o;
  logic [AW-1:0] mem_addr_o;
  logic          wen_o, start_o, layer_valid_i, layer_ready_i;
  logic          busy_o, loaded_o, done_o, err_o;

  int checks = 0;
  int errors = 0;
  int cyc_cnt;

  conv_layer_controller #(
    .N_CONVOLUTIONS(N), .KERNEL_HEIGHT(KH), .KERNEL_WIDTH(KWD),
    .WORD_SIZE(WS), .OUTPUTS_PER_RUN(OPR)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .load_i(load_i), .run_i(run_i),
    .w_valid_i(w_valid_i), .w_yumi_o(w_yumi_o), .w_data_i(w_data_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .wen_o(wen_o),
    .start_o(start_o), .layer_valid_i(layer_valid_i),
    .layer_ready_i(layer_ready_i), .busy_o(busy_o), .loaded_o(loaded_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Write i of a load goes to kernel i/(KS+1), slot i%(KS+1); upper field is kernel+1.
  function automatic logic [31:0] exp_addr(input int i);
    return 32'((((i / (KS + 1)) + 1) << KB) + (i % (KS + 1)));
  endfunction

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_busy"},  busy_o,     0);
    chk({tag, "_wen"},   wen_o,      0);
    chk({tag, "_yumi"},  w_yumi_o,   0);
    chk({tag, "_addr"},  mem_addr_o, 0);
    chk({tag, "_start"}, start_o,    0);
    chk({tag, "_done"},  done_o,     0);
  endtask

  // mode 0: continuous valid, 1: valid on even cycles only, 2: random gaps
  task automatic do_load(input int mode, input bit with_run, output int ld_cycles);
    int idx = 0;
    int cyc = 0;
    logic v;
    logic [WS-1:0] d;
    load_i = 1'b1;
    run_i  = with_run;
    @(negedge clk_i);
    chk("ldreq_err", err_o, 0);
    chk("ldreq_start", start_o, 0);
    tick();
    load_i = 1'b0;
    run_i  = 1'b0;
    while (idx < TOTAL && cyc < 400) begin
      cyc++;
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      d = WS'($urandom);
      if (mode != 2) d = WS'(idx + 1);
      w_valid_i = v;
      w_data_i  = d;
      @(negedge clk_i);
      chk("ld_busy", busy_o, 1);
      chk("ld_loaded", loaded_o, 0);
      chk("ld_wen", wen_o, v);
      chk("ld_yumi", w_yumi_o, v);
      chk("ld_start", start_o, 0);
      if (v) begin
        chk("ld_addr", mem_addr_o, exp_addr(idx));
        chk("ld_data", mem_data_o, d);
      end
      tick();
      if (v) idx++;
    end
    w_valid_i = 1'b0;
    chk("ld_accepts", idx, TOTAL);
    @(negedge clk_i);
    chk("ld_end_loaded", loaded_o, 1);
    chk("ld_end_busy", busy_o, 0);
    chk("ld_end_wen", wen_o, 0);
    ld_cycles = cyc;
    tick();
  endtask

  // mode 0: (valid,ready) alternates stall/handshake; 1: random plus noise on load/run
  task automatic do_run(input int mode);
    int hs = 0;
    int cyc = 0;
    logic lv, lr;
    run_i = 1'b1;
    @(negedge clk_i);
    chk("run_req_err", err_o, 0);
    chk("run_req_start", start_o, 0);
    tick();
    run_i = 1'b0;
    if (mode == 1) begin
      load_i = 1'($urandom_range(0, 1));
      run_i  = 1'($urandom_range(0, 1));
    end
    @(negedge clk_i);
    chk("run_start", start_o, 1);
    chk("run_start_busy", busy_o, 1);
    chk("run_start_err", err_o, 0);
    tick();
    while (hs < OPR && cyc < 200) begin
      cyc++;
      if (mode == 0) begin
        lv = 1'b1;
        lr = (cyc % 2 == 0);
      end else begin
        lv = 1'($urandom_range(0, 1));
        lr = 1'($urandom_range(0, 1));
        load_i = 1'($urandom_range(0, 1));
        run_i  = 1'($urandom_range(0, 1));
      end
      layer_valid_i = lv;
      layer_ready_i = lr;
      @(negedge clk_i);
      chk("run_start_low", start_o, 0);
      chk("run_done_low", done_o, 0);
      chk("run_busy", busy_o, 1);
      chk("run_err", err_o, 0);
      chk("run_wen", wen_o, 0);
      chk("run_addr", mem_addr_o, 0);
      tick();
      if (lv && lr) hs++;
    end
    chk("run_handshakes", hs, OPR);
    layer_valid_i = 1'b0;
    layer_ready_i = 1'b0;
    @(negedge clk_i);
    chk("run_done", done_o, 1);
    chk("run_done_err", err_o, 0);
    tick();
    load_i = 1'b0;
    run_i  = 1'b0;
    @(negedge clk_i);
    chk("run_after_done", done_o, 0);
    chk("run_after_busy", busy_o, 0);
    chk("run_after_loaded", loaded_o, 1);
    tick();
  endtask

  task automatic do_err_run();
    run_i = 1'b1;
    @(negedge clk_i);
    chk("err_pulse", err_o, 1);
    chk("err_start", start_o, 0);
    tick();
    run_i = 1'b0;
    @(negedge clk_i);
    chk("err_clear", err_o, 0);
    chk_idle_outs("err_idle");
    tick();
  endtask

  initial begin
    reset_n_i = 1'b0;
    load_i = 1'b0; run_i = 1'b0; w_valid_i = 1'b0; w_data_i = '0;
    layer_valid_i = 1'b0; layer_ready_i = 1'b0;
    tick(); tick();
    @(negedge clk_i);
    chk_idle_outs("rst");
    chk("rst_loaded", loaded_o, 0);
    chk("rst_err", err_o, 0);
    reset_n_i = 1'b1;
    tick();

    // Run before any load
    do_err_run();

    // Continuous load, then interleaved stall/handshake run
    do_load(0, 1'b0, cyc_cnt);
    chk("ld_cont_cycles", cyc_cnt, TOTAL);
    do_run(0);

    // Every-other-cycle valid
    do_load(1, 1'b0, cyc_cnt);
    chk("ld_toggle_cycles", cyc_cnt, 2 * TOTAL);

    // Handshakes while idle must not count toward the next run
    layer_valid_i = 1'b1;
    layer_ready_i = 1'b1;
    repeat (3) tick();
    layer_valid_i = 1'b0;
    layer_ready_i = 1'b0;
    do_run(1);
    do_run(0);

    // load_i and run_i together while loaded: load wins
    do_load(0, 1'b1, cyc_cnt);

    // Randomized load/run rounds
    for (int r = 0; r < 3; r++) begin
      do_load(2, 1'($urandom_range(0, 1)), cyc_cnt);
      do_run(1);
    end

    // Reset midway through a load (after 5 accepts)
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    w_valid_i = 1'b1;
    w_data_i  = 16'h00aa;
    repeat (5) tick();
    reset_n_i = 1'b0;
    #1;
    chk_idle_outs("midrst");
    chk("midrst_loaded", loaded_o, 0);
    chk("midrst_err", err_o, 0);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    w_valid_i = 1'b0;
    tick();
    do_err_run();
    do_load(0, 1'b0, cyc_cnt);
    chk("ld_after_rst_cycles", cyc_cnt, TOTAL);

    // Reset in the middle of a run: back to idle, no done
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    tick();
    layer_valid_i = 1'b1;
    layer_ready_i = 1'b1;
    tick();
    reset_n_i = 1'b0;
    #1;
    chk("runrst_busy", busy_o, 0);
    chk("runrst_done", done_o, 0);
    chk("runrst_loaded", loaded_o, 0);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    layer_valid_i = 1'b0;
    layer_ready_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      chk("runrst_after_done", done_o, 0);
      chk("runrst_after_busy", busy_o, 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
